// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - N-floor SCAN elevator controller with door timer
// Purpose: latches car and hall requests, serves them in SCAN order and drives
//   the motor command, floor display and door. Optional feature macro:
//   ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   sensor     one-hot floor arrival pulse
//   car_btn    in-car floor buttons (pulses)
//   hall_up    hall up buttons (top floor bit ignored)
//   hall_dn    hall down buttons (bottom floor bit ignored)
//   door_hold  (ELEV_DOOR_HOLD_EN only) reload door timer while high in DOOR
//   ac         motor command: 00 stop, 01 up, 10 down
//   display    current floor index
//   door_open  door drive
//   pending    per-floor OR of latched requests
module elevator_scan_ctrl #(
  parameter int FLOORS      = 4,
  parameter int FW          = 2,
  parameter int DOOR_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] sensor,
  input  logic [FLOORS-1:0] car_btn,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  output logic [1:0]        ac,
  output logic [FW-1:0]     display,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);

  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LOAD = CW'(DOOR_CYCLES - 1);
  localparam logic [FLOORS-1:0] ONES     = '1;
  localparam logic [FLOORS-1:0] ONE      = FLOORS'(1);
  localparam logic [FLOORS-1:0] UP_OK    = ~(ONE << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DN_OK    = ~ONE;
  localparam logic [FW-1:0]     TOP      = FW'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  state_t            state_q, state_d;
  logic              dir_up_q, dir_up_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;

  logic [FLOORS-1:0] req, cur_oh, f_oh;
  logic [FW-1:0]     f;
  logic              arr_up, arr_dn, f_above, f_below, f_end;
  logic              stop, absorb, srv_up, ahead, hold;
  logic [FLOORS-1:0] clr_car, clr_up, clr_dn, abs_car, abs_up, abs_dn;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign req    = car_q | up_q | dn_q;
  assign cur_oh = ONE << floor_q;

  // f is the floor being evaluated this cycle: the arrival floor on an
  // accepted sensor pulse, otherwise the current floor.
  always_comb begin
    arr_up = (state_q == MOVE_UP) && (sensor != '0) && (sensor == (cur_oh << 1));
    arr_dn = (state_q == MOVE_DN) && (sensor != '0) && (sensor == (cur_oh >> 1));
    if (arr_up)      f = floor_q + 1'b1;
    else if (arr_dn) f = floor_q - 1'b1;
    else             f = floor_q;
    f_oh    = ONE << f;
    f_above = |(req & ((ONES << f) << 1));
    f_below = |(req & ~(ONES << f));
    f_end   = (f == TOP) || (f == '0);
  end

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    floor_d  = floor_q;
    cnt_d    = cnt_q;
    stop     = 1'b0;
    absorb   = 1'b0;
    srv_up   = dir_up_q;
    case (state_q)
      IDLE: begin
        if (|(req & f_oh)) begin
          // Serve the opposite direction only when its hall call is the one lit here.
          srv_up   = dir_up_q ? !(|(dn_q & f_oh) && !(|(up_q & f_oh)))
                              :  (|(up_q & f_oh) && !(|(dn_q & f_oh)));
          dir_up_d = srv_up;
          stop     = 1'b1;
          state_d  = DOOR;
          cnt_d    = CNT_LOAD;
        end else if (f_above && (dir_up_q || !f_below)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end else if (f_below) begin
          state_d  = MOVE_DN;
          dir_up_d = 1'b0;
        end
      end
      MOVE_UP: begin
        srv_up = 1'b1;
        if (arr_up) begin
          floor_d = f;
          if (|(f_oh & (car_q | up_q)) || (|(f_oh & dn_q) && !f_above) || (f == TOP)) begin
            stop    = 1'b1;
            state_d = DOOR;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      MOVE_DN: begin
        srv_up = 1'b0;
        if (arr_dn) begin
          floor_d = f;
          if (|(f_oh & (car_q | dn_q)) || (|(f_oh & up_q) && !f_below) || (f == '0)) begin
            stop    = 1'b1;
            state_d = DOOR;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      DOOR: begin
        absorb = 1'b1;
        if (hold)                cnt_d   = CNT_LOAD;
        else if (cnt_q == '0)    state_d = IDLE;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A stop clears the departure-direction hall call; when nothing lies
    // ahead (reversal) or at an end floor both hall calls are served.
    ahead   = srv_up ? f_above : f_below;
    clr_car = stop ? f_oh : '0;
    clr_up  = (stop && (srv_up  || !ahead || f_end)) ? f_oh : '0;
    clr_dn  = (stop && (!srv_up || !ahead || f_end)) ? f_oh : '0;
    // Presses for the floor being served are swallowed while the door cycle runs.
    abs_car = (stop || absorb) ? f_oh : '0;
    abs_up  = ((stop || absorb) && srv_up)  ? f_oh : '0;
    abs_dn  = ((stop || absorb) && !srv_up) ? f_oh : '0;
    car_d   = (car_q & ~clr_car) | (car_btn & ~abs_car);
    up_d    = (up_q  & ~clr_up)  | (hall_up & UP_OK & ~abs_up);
    dn_d    = (dn_q  & ~clr_dn)  | (hall_dn & DN_OK & ~abs_dn);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      dir_up_q <= 1'b1;
      floor_q  <= '0;
      cnt_q    <= '0;
      car_q    <= '0;
      up_q     <= '0;
      dn_q     <= '0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      floor_q  <= floor_d;
      cnt_q    <= cnt_d;
      car_q    <= car_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

  assign ac        = (state_q == MOVE_UP) ? 2'b01 : (state_q == MOVE_DN) ? 2'b10 : 2'b00;
  assign display   = floor_q;
  assign door_open = (state_q == DOOR);
  assign pending   = req;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - scoreboard bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;
  localparam int FLOORS = 4;
  localparam int FW     = 2;
  localparam int DC     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FLOORS-1:0] sensor = '0, car_btn = '0, hall_up = '0, hall_dn = '0;
  logic [1:0]        ac;
  logic [FW-1:0]     display;
  logic              door_open;
  logic [FLOORS-1:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
  logic              door_hold = 1'b0;
`endif

  elevator_scan_ctrl #(.FLOORS(FLOORS), .FW(FW), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .car_btn(car_btn),
    .hall_up(hall_up), .hall_dn(hall_dn),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .ac(ac), .display(display), .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] ac;
    logic [1:0] disp;
    logic       door;
    logic [3:0] pend;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic [1:0] a, input logic [1:0] d,
                          input logic dr, input logic [3:0] p);
    exp_t e;
    e.name = n; e.cyc = cyc; e.ac = a; e.disp = d; e.door = dr; e.pend = p;
    sbq.push_back(e);
  endtask

  task automatic press(input logic [3:0] s, input logic [3:0] c,
                       input logic [3:0] u, input logic [3:0] dn);
    sensor = s; car_btn = c; hall_up = u; hall_dn = dn;
    tick();
    sensor = '0; car_btn = '0; hall_up = '0; hall_dn = '0;
  endtask

  task automatic door_rest(input string n, input logic [1:0] d, input logic [3:0] p);
    for (int i = 0; i < DC - 1; i++) begin
      tick();
      push_exp({n, " door"}, 2'b00, d, 1'b1, p);
    end
    tick();
    push_exp({n, " closed"}, 2'b00, d, 1'b0, p);
  endtask

  task automatic do_reset(input string n);
    rst = 1'b0;
    tick();
    push_exp({n, " rst"}, 2'b00, 2'd0, 1'b0, 4'b0000);
    rst = 1'b1;
    tick();
    push_exp({n, " idle"}, 2'b00, 2'd0, 1'b0, 4'b0000);
  endtask

  // Monitor: pops every expectation due by this cycle and compares it.
  always @(negedge clk) begin
    total++;
    if (ac != 2'b00 && door_open === 1'b1) begin
      bad++;
      $display("FAIL invariant cyc=%0d ac=%b door_open=%b required door_open=0 while moving",
               cyc, ac, door_open);
    end
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      total++;
      if ({ac, display, door_open, pending} !== {mon_e.ac, mon_e.disp, mon_e.door, mon_e.pend}) begin
        bad++;
        $display("FAIL %s: got ac=%b disp=%0d door=%b pend=%b required ac=%b disp=%0d door=%b pend=%b",
                 mon_e.name, ac, display, door_open, pending,
                 mon_e.ac, mon_e.disp, mon_e.door, mon_e.pend);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // reset state
    tick();
    push_exp("reset0", 2'b00, 2'd0, 1'b0, 4'b0000);
    tick();
    push_exp("reset1", 2'b00, 2'd0, 1'b0, 4'b0000);
    rst = 1'b1;
    tick();
    push_exp("reset idle", 2'b00, 2'd0, 1'b0, 4'b0000);

    // hall call up, with absorbed presses during the door
    press(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push_exp("t1 latch", 2'b00, 2'd0, 1'b0, 4'b0100);
    tick();
    push_exp("t1 go", 2'b01, 2'd0, 1'b0, 4'b0100);
    press(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t1 f1", 2'b01, 2'd1, 1'b0, 4'b0100);
    press(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t1 stop2", 2'b00, 2'd2, 1'b1, 4'b0000);
    press(4'b0000, 4'b0100, 4'b0100, 4'b0000);
    push_exp("t1 absorb", 2'b00, 2'd2, 1'b1, 4'b0000);
    tick();
    push_exp("t1 door2", 2'b00, 2'd2, 1'b1, 4'b0000);
    tick();
    push_exp("t1 door3", 2'b00, 2'd2, 1'b1, 4'b0000);
    tick();
    push_exp("t1 closed", 2'b00, 2'd2, 1'b0, 4'b0000);

    // call at current floor
    press(4'b0000, 4'b0100, 4'b0000, 4'b0000);
    push_exp("t2 latch", 2'b00, 2'd2, 1'b0, 4'b0100);
    tick();
    push_exp("t2 door", 2'b00, 2'd2, 1'b1, 4'b0000);
    door_rest("t2", 2'd2, 4'b0000);

    // SCAN pickup en route, reversal at top
    do_reset("t3");
    press(4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push_exp("t3 latch", 2'b00, 2'd0, 1'b0, 4'b1000);
    tick();
    push_exp("t3 go", 2'b01, 2'd0, 1'b0, 4'b1000);
    press(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push_exp("t3 up2", 2'b01, 2'd0, 1'b0, 4'b1100);
    press(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t3 f1", 2'b01, 2'd1, 1'b0, 4'b1100);
    press(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t3 stop2", 2'b00, 2'd2, 1'b1, 4'b1000);
    door_rest("t3a", 2'd2, 4'b1000);
    tick();
    push_exp("t3 resume", 2'b01, 2'd2, 1'b0, 4'b1000);
    press(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t3 stop3", 2'b00, 2'd3, 1'b1, 4'b0000);
    door_rest("t3b", 2'd3, 4'b0000);

    // direction priority from floor 1 with car[0] and car[3]
    do_reset("t4");
    press(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    push_exp("t4 latch", 2'b00, 2'd0, 1'b0, 4'b0010);
    tick();
    push_exp("t4 go", 2'b01, 2'd0, 1'b0, 4'b0010);
    press(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t4 stop1", 2'b00, 2'd1, 1'b1, 4'b0000);
    press(4'b0000, 4'b1001, 4'b0000, 4'b0000);
    push_exp("t4 calls", 2'b00, 2'd1, 1'b1, 4'b1001);
    tick();
    push_exp("t4 door2", 2'b00, 2'd1, 1'b1, 4'b1001);
    tick();
    push_exp("t4 door3", 2'b00, 2'd1, 1'b1, 4'b1001);
    tick();
    push_exp("t4 closed", 2'b00, 2'd1, 1'b0, 4'b1001);
    tick();
    push_exp("t4 up first", 2'b01, 2'd1, 1'b0, 4'b1001);
    press(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t4 pass2", 2'b01, 2'd2, 1'b0, 4'b1001);
    press(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t4 stop3", 2'b00, 2'd3, 1'b1, 4'b0001);
    door_rest("t4", 2'd3, 4'b0001);
    tick();
    push_exp("t4 down", 2'b10, 2'd3, 1'b0, 4'b0001);

    // reset mid-motion, press during reset discarded
    press(4'b0000, 4'b0000, 4'b0000, 4'b1000);
    push_exp("t6 latch", 2'b10, 2'd3, 1'b0, 4'b1001);
    rst = 1'b0;
    hall_dn = 4'b1000;
    tick();
    push_exp("t6 reset", 2'b00, 2'd0, 1'b0, 4'b0000);
    hall_dn = '0;
    rst = 1'b1;
    tick();
    push_exp("t6 after", 2'b00, 2'd0, 1'b0, 4'b0000);

    // ignored hall bits
    press(4'b0000, 4'b0000, 4'b1000, 4'b0001);
    push_exp("ign latch", 2'b00, 2'd0, 1'b0, 4'b0000);
    tick();
    push_exp("ign idle", 2'b00, 2'd0, 1'b0, 4'b0000);

    // illegal sensor patterns while moving up
    press(4'b0000, 4'b0100, 4'b0000, 4'b0000);
    push_exp("t5 latch", 2'b00, 2'd0, 1'b0, 4'b0100);
    tick();
    push_exp("t5 go", 2'b01, 2'd0, 1'b0, 4'b0100);
    press(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t5 skip", 2'b01, 2'd0, 1'b0, 4'b0100);
    press(4'b0110, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t5 multi", 2'b01, 2'd0, 1'b0, 4'b0100);
    tick();
    push_exp("t5 zero", 2'b01, 2'd0, 1'b0, 4'b0100);
    press(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t5 f1", 2'b01, 2'd1, 1'b0, 4'b0100);
    press(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp("t5 stop2", 2'b00, 2'd2, 1'b1, 4'b0000);
    door_rest("t5", 2'd2, 4'b0000);
    press(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    push_exp("idle sensor", 2'b00, 2'd2, 1'b0, 4'b0000);

    repeat (2) tick();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked expectations required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised N-floor elevator controller. Next generation of the 3-floor elevator block.
- Inputs are vectorised floor sensors, car buttons and hall up/down buttons. Requests are latched and served in SCAN order (keep the current direction while requests remain ahead, then reverse).
- A counter-based door timer is included.
- Sits between the button/sensor pulse inputs and the motor, floor-display and door drivers.

Parameters:
- FLOORS, 4, number of floors (2..16); floor 0 is the bottom.
- FW, 2, floor index width; must equal ceil(log2(FLOORS)).
- DOOR_CYCLES, 8, number of cycles door_open stays high per stop (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- sensor  in  FLOORS  one-cycle pulse, one-hot; car has reached floor i.
- car_btn  in  FLOORS  in-car floor buttons, pulses.
- hall_up  in  FLOORS  hall up buttons; bit FLOORS-1 ignored.
- hall_dn  in  FLOORS  hall down buttons; bit 0 ignored.
- ac  out  2  motor command: 00 stop, 01 up, 10 down; 11 never driven.
- display  out  FW  current floor index.
- door_open  out  1  door drive.
- pending  out  FLOORS  OR of latched car/up/down requests per floor (lamps).

Behaviour:
- Reset (rst=0 at clk edge): ac=00, display=0, door_open=0, all request registers cleared, dir=up, state=IDLE, door counter=0.
- Request latch: a button pulse at edge k sets its request bit at k (visible on pending after k). Bits are cleared only by a stop.
- Ignored inputs: hall_up[FLOORS-1], hall_dn[0].
- States: IDLE, MOVE_UP, MOVE_DN, DOOR.
- IDLE decision priority:
  - any request at display -> DOOR;
  - else requests above and (dir=up or none below) -> MOVE_UP, dir=up;
  - else requests below -> MOVE_DN, dir=down;
  - else stay IDLE.
- IDLE decision latency: the decision is made on the edge after the request bit is set, so ac changes 2 edges after the button pulse.
- MOVE_UP:
  - ac=01.
  - Sensor is accepted only if it is exactly display+1. Then display updates on that edge.
  - Stop at floor f if car[f] | up[f] | (dn[f] & no request above f) | f==FLOORS-1.
  - Otherwise continue.
- MOVE_DN: mirror of MOVE_UP. ac=10, accept display-1, stop if car[f] | dn[f] | (up[f] & none below) | f==0.
- Unaccepted sensor pulses: any other pattern (zero, multi-hot, non-adjacent, or a pulse in IDLE/DOOR) is ignored and display is unchanged.
- Stop:
  - Next cycle: ac=00, door_open=1, state=DOOR.
  - Clears car[f] and the hall request in the departure direction.
  - If reversing (no requests ahead) or at an end floor, clears both hall bits at f.
- DOOR:
  - door_open high for exactly DOOR_CYCLES consecutive cycles, then state=IDLE with door_open=0.
  - ac=00 throughout.
- Presses during DOOR for the current floor (car, or hall in the served direction) are absorbed: not latched, timer not extended.
- IDLE after DOOR: at least one cycle with door_open=0 and ac=00 before motion.
- Invariant: ac!=00 implies door_open=0.
- Simultaneous press and stop-clear on the same floor/bit: the clear wins only for absorbed bits as defined above; other bits latch.
- Reset mid-motion or mid-door: immediate return to reset values on that edge. Requests pressed while rst=0 are discarded.

Optional Feature:
- Macro: ELEV_DOOR_HOLD_EN.
- Defined:
  - Adds input port door_hold (1 bit).
  - While in DOOR, door_hold=1 reloads the counter so door_open stays high DOOR_CYCLES cycles after door_hold falls.
  - door_hold in other states is ignored.
- Undefined: no port; door time is fixed at DOOR_CYCLES.

Test Plan:
- Bench settings: FLOORS=4, DOOR_CYCLES=4.
- Hall call up: reset, then hall_up[2] pulse -> pending=0100; ac=01 two edges later; sensor 0010 -> display=1, ac stays 01; sensor 0100 -> display=2, ac=00, door_open high 4 cycles, pending=0000.
- Call at current floor: idle at floor 2, car_btn[2] -> door_open within 2 edges, ac stays 00, 4-cycle door.
- SCAN pickup en route: at floor 0 press hall_dn[3]; while moving up press hall_up[2] before sensor 0100 -> stops at 2 (up request), door, then continues to 3 (reversal at top), clears dn[3].
- Direction priority: at floor 1, dir=up, pending car[0] and car[3] -> goes up to 3 first, then down to 0; ac sequence 01 then 00 (door) then 10.
- Illegal sensor: while MOVE_UP from floor 0, inject sensor 0100 and 0110 -> display stays 0, ac stays 01; then sensor 0010 accepted.
- Reset mid-motion: in MOVE_DN with pending=1001, rst=0 for one edge -> ac=00, display=0, door_open=0, pending=0000; hall_dn[3] pulsed while rst=0 is not latched.
